imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage of the pipelined CPU.
- Decodes the RV32I/RV64I immediate from a 32-bit instruction and sign-extends it to XLEN. Covers I, S, B, U and J formats, including LUI/AUIPC.
- Results go into a small in-order output queue with valid/ready handshakes on both sides, plus a synchronous flush for branch/jump redirects.
- Sits between the IF/ID register and the ID/EX stage; absorbs downstream stalls without losing instructions.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- DEPTH, 2, output queue entries; power of two, at least 2.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous queue clear (pipeline redirect).
- instr_valid_i  input  1  instruction beat valid.
- instr_ready_o  output  1  block can accept a beat.
- instr_data_i  input  32  instruction word.
- imm_valid_o  output  1  head entry valid.
- imm_ready_i  input  1  consumer takes head entry.
- imm_data_o  output  XLEN  sign-extended immediate of head entry.
- imm_type_o  output  3  format of head entry: 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J.
- count_o  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Opcode decode on instr_data_i[6:2]:
  - 01100 (OP) -> R: imm 0, type 0.
  - 00100 (OP-IMM), 00000 (LOAD), 11001 (JALR) -> I.
  - 01000 (STORE) -> S.
  - 11000 (BRANCH) -> B.
  - 01101 (LUI), 00101 (AUIPC) -> U.
  - 11011 (JAL) -> J.
- When XLEN=64, additionally: 00110 (OP-IMM-32) -> I; 01110 (OP-32) -> R.
- Any other opcode -> imm 0, type 0.
- Immediate bit fields, before sign extension to XLEN from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}; for XLEN=64, bits 63:32 replicate instr[31].
- Handshakes:
  - Accept when instr_valid_i && instr_ready_o.
  - Pop when imm_valid_o && imm_ready_i.
  - instr_ready_o = (count_o < DEPTH); it does not depend combinationally on imm_ready_i.
  - When full, no accept in that cycle, even if a pop occurs.
- Latency:
  - An accepted beat appears at the output the next cycle if the queue was empty.
  - Otherwise it appears after all older entries pop. Strictly in order.
- Queue implementation:
  - Circular buffer with read/write pointers that wrap modulo DEPTH.
  - Push and pop in the same cycle leaves count_o unchanged.
  - Push into an empty queue with imm_ready_i=1: the entry is visible next cycle; no combinational bypass.
- Output stability and idle values:
  - While imm_valid_o=1 and imm_ready_i=0, imm_data_o and imm_type_o hold stable.
  - When the queue is empty: imm_valid_o=0, imm_data_o=0, imm_type_o=0.
- Flush:
  - flush_i=1 clears pointers and count on that edge.
  - Any accept or pop in the same cycle is discarded.
  - The next cycle shows imm_valid_o=0, count_o=0, instr_ready_o=1.
- Reset:
  - rst_i has priority over flush_i.
  - Reset values: count_o=0, imm_valid_o=0, imm_data_o=0, imm_type_o=0, instr_ready_o=1.
  - Asserting reset mid-stream drops all queued entries.
- Storage entries are not required to be cleared on reset or flush; only pointers and count.

Optional Feature:
- Macro IMM_GEN_PIPE_ILLEGAL_EN.
- When defined:
  - Adds output illegal_o (1 bit), stored per entry.
  - illegal_o is set when the opcode is unrecognised or instr[1:0] != 2'b11.
  - The entry is still queued with imm 0, type 0.
  - illegal_o=0 when the queue is empty and on reset.
- When undefined: the port does not exist and unrecognised opcodes only yield imm 0, type 0.

Test Plan:
- XLEN=32, queue empty, push 0xFFF00093 (addi x1,x0,-1) -> next cycle imm_valid_o=1, imm_data_o=0xFFFFFFFF, imm_type_o=1.
- Push 0xFE112E23 (sw x1,-4(x2)) -> imm_data_o=0xFFFFFFFC, type 2. Push 0xFF9FF06F (jal x0,-8) -> imm_data_o=0xFFFFFFF8, type 5.
- XLEN=64: push 0x123452B7 (lui) -> 0x0000000012345000, type 4. Push 0x800002B7 -> 0xFFFFFFFF80000000, type 4.
- DEPTH=2, imm_ready_i=0, push A, B, C back-to-back:
  - instr_ready_o drops after B; C is held; count_o=2.
  - Raise imm_ready_i -> A then B pop on consecutive cycles with outputs stable while stalled.
  - C is accepted in the cycle after A pops; order A, B, C.
- Queue full, flush_i=1 with instr_valid_i=1 in the same cycle -> next cycle count_o=0, imm_valid_o=0, imm_data_o=0; flushed beat never emerges.
- Reset with two entries queued plus flush_i=1 -> outputs at reset values next cycle.
- With IMM_GEN_PIPE_ILLEGAL_EN defined, push 0x0000007F -> illegal_o=1, imm_data_o=0, type 0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with an in-order valid/ready output queue.
// Optional macro IMM_GEN_PIPE_ILLEGAL_EN adds a per-entry illegal_o flag.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     instr_valid_i,
    output logic                     instr_ready_o,
    input  logic [31:0]              instr_data_i,
    output logic                     imm_valid_o,
    input  logic                     imm_ready_i,
    output logic [XLEN-1:0]          imm_data_o,
    output logic [2:0]               imm_type_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    ,
    output logic                     illegal_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_S    = 3'd2;
    localparam logic [2:0] TYPE_B    = 3'd3;
    localparam logic [2:0] TYPE_U    = 3'd4;
    localparam logic [2:0] TYPE_J    = 3'd5;

    localparam logic [4:0] OPC_LOAD      = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_STORE     = 5'b01000;
    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_JAL       = 5'b11011;

    logic [31:0]     ins;
    logic [31:0]     dec_imm32;
    logic [2:0]      dec_type;
    logic            dec_known;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type_q;

    assign ins = instr_data_i;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        dec_imm32 = '0;
        dec_type  = TYPE_NONE;
        dec_known = 1'b0;
        case (ins[6:2])
            OPC_OP: dec_known = 1'b1;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                dec_known = 1'b1;
                dec_type  = TYPE_I;
                dec_imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            OPC_STORE: begin
                dec_known = 1'b1;
                dec_type  = TYPE_S;
                dec_imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            OPC_BRANCH: begin
                dec_known = 1'b1;
                dec_type  = TYPE_B;
                dec_imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_known = 1'b1;
                dec_type  = TYPE_U;
                dec_imm32 = {ins[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec_known = 1'b1;
                dec_type  = TYPE_J;
                dec_imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    dec_known = 1'b1;
                    dec_type  = TYPE_I;
                    dec_imm32 = {{20{ins[31]}}, ins[31:20]};
                end
            end
            OPC_OP_32: dec_known = (XLEN == 64);
            default: ;
        endcase
    end

`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    logic dec_illegal;
    assign dec_illegal = !dec_known || (ins[1:0] != 2'b11);
    // Illegal beats still occupy a slot so the pipeline stays in lock-step with fetch.
    assign dec_imm    = dec_illegal ? '0 : XLEN'($signed(dec_imm32));
    assign dec_type_q = dec_illegal ? TYPE_NONE : dec_type;
`else
    logic unused_bits;
    assign unused_bits = ^{ins[1:0], dec_known};
    assign dec_imm    = XLEN'($signed(dec_imm32));
    assign dec_type_q = dec_type;
`endif

    logic [XLEN-1:0] mem_imm  [DEPTH];
    logic [2:0]      mem_type [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic            push;
    logic            pop;

    assign instr_ready_o = (count_o < FULL_CNT);
    assign imm_valid_o   = (count_o != '0);
    assign push          = instr_valid_i && instr_ready_o;
    assign pop           = imm_valid_o && imm_ready_i;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_imm[wr_ptr]  <= dec_imm;
            mem_type[wr_ptr] <= dec_type_q;
        end
    end

    assign imm_data_o = imm_valid_o ? mem_imm[rd_ptr]  : '0;
    assign imm_type_o = imm_valid_o ? mem_type[rd_ptr] : TYPE_NONE;

`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    logic mem_ill [DEPTH];

    always_ff @(posedge clk_i) begin
        if (push) mem_ill[wr_ptr] <= dec_illegal;
    end

    assign illegal_o = imm_valid_o ? mem_ill[rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed plan cases plus randomized traffic against a queue model,
// run on an XLEN=32/DEPTH=2 instance and an XLEN=64/DEPTH=4 instance sharing one stimulus.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        imm_ready;

    logic        rdy32, val32, rdy64, val64;
    logic [31:0] data32;
    logic [63:0] data64;
    logic [2:0]  type32, type64;
    logic [1:0]  count32;
    logic [2:0]  count64;
    logic        ill32, ill64;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        longint imm;
        int     typ;
        bit     ill;
    } ent_t;

    ent_t q32[$];
    ent_t q64[$];

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ready_o(rdy32), .instr_data_i(instr_data),
        .imm_valid_o(val32), .imm_ready_i(imm_ready), .imm_data_o(data32),
        .imm_type_o(type32), .count_o(count32)
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
        , .illegal_o(ill32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(4)) dut64 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ready_o(rdy64), .instr_data_i(instr_data),
        .imm_valid_o(val64), .imm_ready_i(imm_ready), .imm_data_o(data64),
        .imm_type_o(type64), .count_o(count64)
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
        , .illegal_o(ill64)
`endif
    );

`ifndef IMM_GEN_PIPE_ILLEGAL_EN
    assign ill32 = 1'b0;
    assign ill64 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: immediates as two's-complement weighted sums of the instruction fields.
    function automatic ent_t ref_decode(input logic [31:0] ins, input bit is64);
        ent_t e;
        bit   known = 1'b1;
        longint s = longint'(ins[31]);
        e.imm = 0;
        e.typ = 0;
        case (ins[6:2])
            5'b01100: ;
            5'b00100, 5'b00000, 5'b11001: begin
                e.typ = 1; e.imm = longint'(ins[30:20]) - s * 2048;
            end
            5'b01000: begin
                e.typ = 2; e.imm = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - s * 2048;
            end
            5'b11000: begin
                e.typ = 3;
                e.imm = longint'(ins[11:8]) * 2 + longint'(ins[30:25]) * 32
                      + longint'(ins[7]) * 2048 - s * 4096;
            end
            5'b01101, 5'b00101: begin
                e.typ = 4; e.imm = longint'(ins[30:12]) * 4096 - s * 64'sh8000_0000;
            end
            5'b11011: begin
                e.typ = 5;
                e.imm = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048
                      + longint'(ins[19:12]) * 4096 - s * 1048576;
            end
            5'b00110: begin
                if (is64) begin e.typ = 1; e.imm = longint'(ins[30:20]) - s * 2048; end
                else known = 1'b0;
            end
            5'b01110: known = is64;
            default: known = 1'b0;
        endcase
        e.ill = !known || (ins[1:0] != 2'b11);
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
        if (e.ill) begin e.imm = 0; e.typ = 0; end
`else
        e.ill = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  opcs [12] = '{5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000, 5'b11000,
                                   5'b01101, 5'b00101, 5'b11011, 5'b00110, 5'b01110, 5'b11111};
        logic [31:0] w = $urandom;
        w[6:2] = opcs[$urandom_range(0, 11)];
        if ($urandom_range(0, 3) == 0) w[6:2] = 5'($urandom);
        w[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
        return w;
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; instr_valid = 1'b0; imm_ready = 1'b0; instr_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1; instr_valid = 1'b1; imm_ready = 1'b1; instr_data = 32'hFFF0_0093;
        tick();
        n_tests++;
        if ({val32, rdy32, count32, data32, type32, ill32} !== {1'b0, 1'b1, 2'd0, 32'd0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset32: valid=%b ready=%b count=%0d data=%h type=%0d ill=%b, need 0 1 0 0 0 0",
                     val32, rdy32, count32, data32, type32, ill32);
        end
        n_tests++;
        if ({val64, rdy64, count64, data64, type64, ill64} !== {1'b0, 1'b1, 3'd0, 64'd0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset64: valid=%b ready=%b count=%0d data=%h type=%0d ill=%b, need 0 1 0 0 0 0",
                     val64, rdy64, count64, data64, type64, ill64);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_decode32();
        logic [31:0] ins  [3] = '{32'hFFF0_0093, 32'hFE11_2E23, 32'hFF9F_F06F};
        logic [31:0] want [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
        logic [2:0]  wtyp [3] = '{3'd1, 3'd2, 3'd5};
        imm_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_valid = 1'b1;
            instr_data  = ins[i];
            tick();
            n_tests++;
            if ({val32, count32, data32, type32} !== {1'b1, 2'd1, want[i], wtyp[i]}) begin
                n_fail++;
                $display("FAIL decode32[%0d]: valid=%b count=%0d data=%h type=%0d, need 1 1 %h %0d",
                         i, val32, count32, data32, type32, want[i], wtyp[i]);
            end
            n_tests++;
            if (data64 !== {32'hFFFF_FFFF, want[i]}) begin
                n_fail++;
                $display("FAIL decode64[%0d]: data=%h need %h", i, data64, {32'hFFFF_FFFF, want[i]});
            end
        end
        instr_valid = 1'b0;
        tick();
        n_tests++;
        if ({val32, count32, data32, type32} !== {1'b0, 2'd0, 32'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL drain32: valid=%b count=%0d data=%h type=%0d, need 0 0 0 0",
                     val32, count32, data32, type32);
        end
        idle_inputs();
    endtask

    task automatic test_u64();
        logic [31:0] ins  [2] = '{32'h1234_52B7, 32'h8000_02B7};
        logic [63:0] want [2] = '{64'h0000_0000_1234_5000, 64'hFFFF_FFFF_8000_0000};
        imm_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instr_valid = 1'b1;
            instr_data  = ins[i];
            tick();
            n_tests++;
            if ({val64, data64, type64} !== {1'b1, want[i], 3'd4}) begin
                n_fail++;
                $display("FAIL lui64[%0d]: valid=%b data=%h type=%0d, need 1 %h 4",
                         i, val64, data64, type64, want[i]);
            end
            n_tests++;
            if ({data32, type32} !== {want[i][31:0], 3'd4}) begin
                n_fail++;
                $display("FAIL lui32[%0d]: data=%h type=%0d, need %h 4", i, data32, type32, want[i][31:0]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a = 32'hFFF0_0093, b = 32'hFE11_2E23, c = 32'hFF9F_F06F;
        rst = 1'b1; tick(); idle_inputs();
        instr_valid = 1'b1; instr_data = a;
        tick();
        instr_data = b;
        tick();
        n_tests++;
        if ({rdy32, count32, data32, type32} !== {1'b0, 2'd2, 32'hFFFF_FFFF, 3'd1}) begin
            n_fail++;
            $display("FAIL b2b_full: ready=%b count=%0d data=%h type=%0d, need 0 2 ffffffff 1",
                     rdy32, count32, data32, type32);
        end
        instr_data = c;
        tick();
        n_tests++;
        if ({rdy32, count32, data32, type32} !== {1'b0, 2'd2, 32'hFFFF_FFFF, 3'd1}) begin
            n_fail++;
            $display("FAIL b2b_stall: ready=%b count=%0d data=%h type=%0d, need 0 2 ffffffff 1",
                     rdy32, count32, data32, type32);
        end
        imm_ready = 1'b1;
        tick();
        n_tests++;
        if ({rdy32, count32, data32, type32} !== {1'b1, 2'd1, 32'hFFFF_FFFC, 3'd2}) begin
            n_fail++;
            $display("FAIL b2b_popA: ready=%b count=%0d data=%h type=%0d, need 1 1 fffffffc 2",
                     rdy32, count32, data32, type32);
        end
        tick();
        n_tests++;
        if ({val32, count32, data32, type32} !== {1'b1, 2'd1, 32'hFFFF_FFF8, 3'd5}) begin
            n_fail++;
            $display("FAIL b2b_popB: valid=%b count=%0d data=%h type=%0d, need 1 1 fffffff8 5",
                     val32, count32, data32, type32);
        end
        instr_valid = 1'b0;
        tick();
        n_tests++;
        if ({val32, count32} !== {1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL b2b_popC: valid=%b count=%0d, need 0 0", val32, count32);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        instr_valid = 1'b1;
        instr_data = 32'h0010_0093;
        tick();
        instr_data = 32'h0020_0093;
        tick();
        flush = 1'b1; imm_ready = 1'b1; instr_data = 32'hFF9F_F06F;
        tick();
        n_tests++;
        if ({val32, rdy32, count32, data32, type32} !== {1'b0, 1'b1, 2'd0, 32'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL flush: valid=%b ready=%b count=%0d data=%h type=%0d, need 0 1 0 0 0",
                     val32, rdy32, count32, data32, type32);
        end
        idle_inputs();
        imm_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({val32, val64} !== 2'b00) begin
                n_fail++;
                $display("FAIL flush_ghost[%0d]: valid32=%b valid64=%b, need 0 0", i, val32, val64);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        instr_valid = 1'b1;
        instr_data = 32'h0010_0093;
        tick();
        instr_data = 32'h0020_0093;
        tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        n_tests++;
        if ({val32, rdy32, count32, data32, type32} !== {1'b0, 1'b1, 2'd0, 32'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL rst_mid32: valid=%b ready=%b count=%0d data=%h type=%0d, need 0 1 0 0 0",
                     val32, rdy32, count32, data32, type32);
        end
        n_tests++;
        if ({val64, count64, data64} !== {1'b0, 3'd0, 64'd0}) begin
            n_fail++;
            $display("FAIL rst_mid64: valid=%b count=%0d data=%h, need 0 0 0", val64, count64, data64);
        end
        idle_inputs();
    endtask

`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    task automatic test_illegal();
        instr_valid = 1'b1; imm_ready = 1'b1; instr_data = 32'h0000_007F;
        tick();
        n_tests++;
        if ({val32, ill32, data32, type32} !== {1'b1, 1'b1, 32'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL illegal: valid=%b ill=%b data=%h type=%0d, need 1 1 0 0",
                     val32, ill32, data32, type32);
        end
        instr_valid = 1'b0;
        tick();
        n_tests++;
        if ({val32, ill32} !== 2'b00) begin
            n_fail++;
            $display("FAIL illegal_idle: valid=%b ill=%b, need 0 0", val32, ill32);
        end
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        ent_t h32, h64;
        bit acc32, acc64, pop32, pop64;
        rst = 1'b1; tick(); idle_inputs();
        q32.delete(); q64.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst         = ($urandom_range(0, 79) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            imm_ready   = ($urandom_range(0, 2) != 0);
            instr_data  = rand_instr();
            h32 = '{imm: 0, typ: 0, ill: 1'b0};
            h64 = '{imm: 0, typ: 0, ill: 1'b0};
            if (q32.size() > 0) h32 = q32[0];
            if (q64.size() > 0) h64 = q64[0];
            n_tests++;
            if ({val32, rdy32, count32} !== {q32.size() > 0, q32.size() < 2, 2'(q32.size())}) begin
                n_fail++;
                $display("FAIL rnd32_ctl@%0d: valid=%b ready=%b count=%0d, need size %0d",
                         cyc, val32, rdy32, count32, q32.size());
            end
            n_tests++;
            if ({data32, type32, ill32} !== {h32.imm[31:0], 3'(h32.typ), h32.ill}) begin
                n_fail++;
                $display("FAIL rnd32_data@%0d: data=%h type=%0d ill=%b, need %h %0d %b",
                         cyc, data32, type32, ill32, h32.imm[31:0], h32.typ, h32.ill);
            end
            n_tests++;
            if ({val64, rdy64, count64} !== {q64.size() > 0, q64.size() < 4, 3'(q64.size())}) begin
                n_fail++;
                $display("FAIL rnd64_ctl@%0d: valid=%b ready=%b count=%0d, need size %0d",
                         cyc, val64, rdy64, count64, q64.size());
            end
            n_tests++;
            if ({data64, type64, ill64} !== {h64.imm, 3'(h64.typ), h64.ill}) begin
                n_fail++;
                $display("FAIL rnd64_data@%0d: data=%h type=%0d ill=%b, need %h %0d %b",
                         cyc, data64, type64, ill64, h64.imm, h64.typ, h64.ill);
            end
            acc32 = instr_valid && (q32.size() < 2);
            acc64 = instr_valid && (q64.size() < 4);
            pop32 = imm_ready && (q32.size() > 0);
            pop64 = imm_ready && (q64.size() > 0);
            tick();
            if (rst || flush) begin
                q32.delete();
                q64.delete();
            end else begin
                if (pop32) void'(q32.pop_front());
                if (pop64) void'(q64.pop_front());
                if (acc32) q32.push_back(ref_decode(instr_data, 1'b0));
                if (acc64) q64.push_back(ref_decode(instr_data, 1'b1));
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        test_reset();
        test_decode32();
        test_u64();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
        test_illegal();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
